// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one elastic pipeline stage: upstream valid/ready/data in,
// downstream valid/ready/data out. master drives the stage, slave is the stage.
interface pipe_stage_skid_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: main entry plus one-entry skid buffer, registered
// in_ready, synchronous flush and a saturating back-pressure (stall) counter.
module pipe_stage_skid #(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_DATA     = {WIDTH{1'b0}},
    parameter bit               CLEAR_ON_FLUSH = 1'b1,
    parameter int               CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    pipe_stage_skid_if.slave    bus,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    stall_cnt,
    input  logic                stall_cnt_clr
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             m_v, s_v, rdy_q;
    logic [WIDTH-1:0] m_d, s_d;
    logic             m_v_n, s_v_n;
    logic [WIDTH-1:0] m_d_n, s_d_n;
    logic [CNT_W-1:0] cnt_n;
    logic             in_fire, out_fire;

    assign in_fire  = bus.in_valid & rdy_q;
    assign out_fire = m_v & bus.out_ready;

    always_comb begin
        m_v_n = m_v;
        s_v_n = s_v;
        m_d_n = m_d;
        s_d_n = s_d;
        if (flush) begin
            // A beat handshaked this cycle belongs to the killed path and is dropped.
            m_v_n = 1'b0;
            s_v_n = 1'b0;
            if (CLEAR_ON_FLUSH) m_d_n = RESET_DATA;
        end else if (!m_v || out_fire) begin
            if (s_v) begin
                m_v_n = 1'b1;
                m_d_n = s_d;
                s_v_n = 1'b0;
            end else if (in_fire) begin
                m_v_n = 1'b1;
                m_d_n = bus.in_data;
            end else begin
                m_v_n = 1'b0;
            end
        end else if (in_fire) begin
            // First stalled cycle: the beat already in flight parks in the skid.
            s_v_n = 1'b1;
            s_d_n = bus.in_data;
        end
    end

    always_comb begin
        cnt_n = stall_cnt;
        if (stall_cnt_clr)              cnt_n = '0;
        else if (m_v && !bus.out_ready) cnt_n = sat_inc(stall_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_v       <= 1'b0;
            s_v       <= 1'b0;
            rdy_q     <= 1'b1;
            m_d       <= RESET_DATA;
            s_d       <= RESET_DATA;
            stall_cnt <= '0;
        end else begin
            m_v       <= m_v_n;
            s_v       <= s_v_n;
            rdy_q     <= !s_v_n;
            m_d       <= m_d_n;
            s_d       <= s_d_n;
            stall_cnt <= cnt_n;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = m_v;
    assign bus.out_data  = m_d;
    assign occupancy     = {1'b0, m_v} + {1'b0, s_v};

endmodule
